// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP weight-memory arbiter.
package mlp_pkg;

   localparam int unsigned MLP_ADDR_W = 11;
   localparam int unsigned MLP_DATA_W = 8;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      CPrio  = 2'd0,
      HForce = 2'd1,
      Locked = 2'd2
   } arb_state_t;

   typedef enum logic {
      OwnC = 1'b0,
      OwnH = 1'b1
   } owner_t;

   // Read-return tag carried alongside the SRAM latency
   typedef struct packed {
      logic   valid;
      owner_t owner;
   } rd_tag_t;

endpackage

// File: rtl/mlp_rd_tag_pipe.sv
// Latency-matched shift register routing read returns to their issuer.
module mlp_rd_tag_pipe
   import mlp_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t [RD_LAT-1:0] pipe_q;

   // Shift one stage per cycle; reset drops every in-flight tag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= tag_i;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mlp_wmem_arb.sv
// Single-port weight SRAM arbiter: compute priority, bounded host starvation,
// lock for layer bursts, and tagged read-data return.
module mlp_wmem_arb
   import mlp_pkg::*;
#(
   parameter int unsigned ADDR_W     = MLP_ADDR_W,
   parameter int unsigned DATA_W     = MLP_DATA_W,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              c_req_i,
   input  logic [ADDR_W-1:0] c_addr_i,
   input  logic              c_lock_i,
   output logic              c_gnt_o,
   output logic              c_rvalid_o,
   output logic [DATA_W-1:0] c_rdata_o,
   input  logic              h_req_i,
   input  logic              h_we_i,
   input  logic [ADDR_W-1:0] h_addr_i,
   input  logic [DATA_W-1:0] h_wdata_i,
   output logic              h_gnt_o,
   output logic              h_rvalid_o,
   output logic [DATA_W-1:0] h_rdata_o,
   output logic              w_ren_o,
   output logic              w_wen_o,
   output logic [ADDR_W-1:0] w_addr_o,
   output logic [DATA_W-1:0] w_wdata_o,
   input  logic [DATA_W-1:0] w_rdata_i
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              c_gnt, h_gnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   rd_tag_t           tag_in, tag_out;

   // Denial step saturates, so a limit held across a lock re-fires on the next denial
   always_comb begin
      cnt_inc = (cnt_q >= STARVE_LIM) ? STARVE_LIM : cnt_q + CNT_W'(1);
   end

   // Arbitration: next state, starve counter and grants
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c_gnt   = 1'b0;
      h_gnt   = 1'b0;
      if (rst_ni) begin
         if (c_lock_i) begin
            state_d = Locked;
            c_gnt   = c_req_i;
         end else if (state_q == HForce) begin
            state_d = CPrio;
            cnt_d   = '0;
            if (h_req_i) begin
               h_gnt = 1'b1;
            end else begin
               c_gnt = c_req_i;
            end
         end else begin
            // CPrio, or the first cycle after a lock releases
            state_d = CPrio;
            if (c_req_i) begin
               c_gnt = 1'b1;
               if (h_req_i) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= STARVE_LIM) begin
                     state_d = HForce;
                  end
               end
            end else if (h_req_i) begin
               h_gnt = 1'b1;
               cnt_d = '0;
            end
         end
      end
   end

   // Arbiter state and starve counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CPrio;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign c_gnt_o   = c_gnt;
   assign h_gnt_o   = h_gnt;
   assign w_ren_o   = c_gnt | (h_gnt & ~h_we_i);
   assign w_wen_o   = h_gnt & h_we_i;
   assign w_addr_o  = c_gnt ? c_addr_i : (h_gnt ? h_addr_i : addr_q);
   assign w_wdata_o = h_gnt ? h_wdata_i : wdata_q;

   // Hold the last SRAM address/data while the port is idle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         addr_q  <= w_addr_o;
         wdata_q <= w_wdata_o;
      end
   end

   // Tag each issued read with its owner
   always_comb begin
      tag_in.valid = w_ren_o;
      tag_in.owner = h_gnt ? OwnH : OwnC;
   end

   mlp_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tag_i  (tag_in),
      .tag_o  (tag_out)
   );

   assign c_rvalid_o = tag_out.valid & (tag_out.owner == OwnC);
   assign h_rvalid_o = tag_out.valid & (tag_out.owner == OwnH);
   assign c_rdata_o  = w_rdata_i;
   assign h_rdata_o  = w_rdata_i;

endmodule

// File: tb/tb_mlp_wmem_arb.sv
// Bench for mlp_wmem_arb: per-cycle grant vectors plus a read-return scoreboard.
module tb_mlp_wmem_arb;

   localparam int unsigned AW     = 11;
   localparam int unsigned DW     = 8;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned SMAX   = 4;

   logic          clk;
   logic          rst_n;
   logic          c_req, c_lock, c_gnt, c_rvalid;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_rdata;
   logic          h_req, h_we, h_gnt, h_rvalid;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata, h_rdata;
   logic          w_ren, w_wen;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata, w_rdata;

   mlp_wmem_arb #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LAT     (RD_LAT),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .c_req_i    (c_req),
      .c_addr_i   (c_addr),
      .c_lock_i   (c_lock),
      .c_gnt_o    (c_gnt),
      .c_rvalid_o (c_rvalid),
      .c_rdata_o  (c_rdata),
      .h_req_i    (h_req),
      .h_we_i     (h_we),
      .h_addr_i   (h_addr),
      .h_wdata_i  (h_wdata),
      .h_gnt_o    (h_gnt),
      .h_rvalid_o (h_rvalid),
      .h_rdata_o  (h_rdata),
      .w_ren_o    (w_ren),
      .w_wen_o    (w_wen),
      .w_addr_o   (w_addr),
      .w_wdata_o  (w_wdata),
      .w_rdata_i  (w_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      return (a == 16) ? 8'hA5 : 8'(a * 7 + 3);
   endfunction

   // SRAM macro model with RD_LAT-cycle read latency
   logic [DW-1:0] mem    [2048];
   bit            wr_vld [2048];
   logic [DW-1:0] rdq    [RD_LAT];
   logic [DW-1:0] rd_now;

   always_comb rd_now = wr_vld[w_addr] ? mem[w_addr] : init_val(int'(w_addr));

   always @(posedge clk) begin
      if (w_wen) begin
         mem[w_addr]    <= w_wdata;
         wr_vld[w_addr] <= 1'b1;
      end
      rdq[0] <= rd_now;
      for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
   end
   assign w_rdata = rdq[RD_LAT-1];

   typedef struct {
      logic          c_req;
      logic [AW-1:0] c_addr;
      logic          c_lock;
      logic          h_req;
      logic          h_we;
      logic [AW-1:0] h_addr;
      logic [DW-1:0] h_wdata;
      logic          exp_c;
      logic          exp_h;
   } vec_t;

   typedef struct {
      logic          own_h;
      logic [DW-1:0] data;
      int            due;
   } sb_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   sb_t           sb[$];
   logic [DW-1:0] shadow [2048];
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wd;
   logic          wd_known;
   vec_t          tbl[$];

   function automatic vec_t mk(input logic cr, input int ca, input logic lk,
                               input logic hr, input logic hw, input int ha,
                               input int hd, input logic ec, input logic eh);
      vec_t v;
      v.c_req = cr; v.c_addr = AW'(ca); v.c_lock = lk;
      v.h_req = hr; v.h_we = hw; v.h_addr = AW'(ha); v.h_wdata = DW'(hd);
      v.exp_c = ec; v.exp_h = eh;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, update expectations
   task automatic step(input vec_t v);
      sb_t  e;
      logic exp_cv, exp_hv;
      logic [DW-1:0] exp_d;
      c_req = v.c_req; c_addr = v.c_addr; c_lock = v.c_lock;
      h_req = v.h_req; h_we = v.h_we; h_addr = v.h_addr; h_wdata = v.h_wdata;
      @(negedge clk);
      exp_cv = 1'b0; exp_hv = 1'b0; exp_d = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.own_h) exp_hv = 1'b1; else exp_cv = 1'b1;
         exp_d = e.data;
      end
      chk("rvalid{c,h}", 32'({c_rvalid, h_rvalid}), 32'({exp_cv, exp_hv}));
      if (exp_cv) chk("c_rdata", 32'(c_rdata), 32'(exp_d));
      if (exp_hv) chk("h_rdata", 32'(h_rdata), 32'(exp_d));
      chk("gnt{c,h}", 32'({c_gnt, h_gnt}), 32'({v.exp_c, v.exp_h}));
      if (v.exp_c) begin
         chk("c_cmd{ren,wen}", 32'({w_ren, w_wen}), 32'(2'b10));
         chk("c_addr", 32'(w_addr), 32'(v.c_addr));
         e.own_h = 1'b0; e.data = shadow[v.c_addr]; e.due = cyc + RD_LAT;
         sb.push_back(e);
         last_addr = v.c_addr; wd_known = 1'b0;
      end else if (v.exp_h) begin
         chk("h_cmd{ren,wen}", 32'({w_ren, w_wen}), 32'({~v.h_we, v.h_we}));
         chk("h_addr", 32'(w_addr), 32'(v.h_addr));
         last_addr = v.h_addr;
         if (v.h_we) begin
            chk("h_wdata", 32'(w_wdata), 32'(v.h_wdata));
            shadow[v.h_addr] = v.h_wdata;
            last_wd = v.h_wdata; wd_known = 1'b1;
         end else begin
            e.own_h = 1'b1; e.data = shadow[v.h_addr]; e.due = cyc + RD_LAT;
            sb.push_back(e);
            wd_known = 1'b0;
         end
      end else begin
         chk("idle{ren,wen}", 32'({w_ren, w_wen}), 32'(0));
         chk("idle_addr_hold", 32'(w_addr), 32'(last_addr));
         if (wd_known) chk("idle_wdata_hold", 32'(w_wdata), 32'(last_wd));
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
      last_addr = '0; last_wd = '0; wd_known = 1'b1;
      rst_n = 1'b0;

      // Reset held with both requesting: nothing granted, outputs zero
      step(mk(1, 'h020, 0, 1, 0, 'h010, 0, 0, 0));
      step(mk(1, 'h020, 0, 1, 0, 'h010, 0, 0, 0));
      rst_n = 1'b1;
      step(mk(1, 'h020, 0, 1, 0, 'h010, 0, 1, 0));
      step(mk(0, 'h020, 0, 1, 0, 'h010, 0, 0, 1));

      // Starvation, write/readback at top address, idle hold, alternating reads
      tbl.push_back(mk(1, 'h001, 0, 1, 0, 'h100, 0, 1, 0));
      tbl.push_back(mk(1, 'h002, 0, 1, 0, 'h100, 0, 1, 0));
      tbl.push_back(mk(1, 'h003, 0, 1, 0, 'h100, 0, 1, 0));
      tbl.push_back(mk(1, 'h004, 0, 1, 0, 'h100, 0, 1, 0));
      tbl.push_back(mk(1, 'h005, 0, 1, 0, 'h100, 0, 0, 1));
      tbl.push_back(mk(1, 'h005, 0, 0, 0, 'h000, 0, 1, 0));
      tbl.push_back(mk(0, 'h000, 0, 1, 1, 'h7FF, 'h3C, 0, 1));
      tbl.push_back(mk(1, 'h7FF, 0, 0, 0, 'h000, 0, 1, 0));
      tbl.push_back(mk(0, 'h000, 0, 0, 0, 'h000, 0, 0, 0));
      tbl.push_back(mk(0, 'h000, 0, 1, 0, 'h000, 0, 0, 1));
      tbl.push_back(mk(1, 'h000, 0, 1, 0, 'h7FE, 0, 1, 0));
      tbl.push_back(mk(0, 'h000, 0, 1, 0, 'h7FE, 0, 0, 1));
      tbl.push_back(mk(1, 'h7FD, 0, 0, 0, 'h000, 0, 1, 0));
      tbl.push_back(mk(0, 'h000, 0, 1, 0, 'h010, 0, 0, 1));
      tbl.push_back(mk(0, 'h000, 0, 1, 1, 'h010, 'h77, 0, 1));
      tbl.push_back(mk(1, 'h010, 0, 0, 0, 'h000, 0, 1, 0));
      for (int i = 0; i <= RD_LAT; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Counter reaches 2, lock for 20 cycles, then 2 denials before forced grant
      step(mk(1, 'h040, 0, 1, 0, 'h050, 0, 1, 0));
      step(mk(1, 'h041, 0, 1, 0, 'h050, 0, 1, 0));
      for (int i = 0; i < 20; i++) begin
         if (i == 10) step(mk(0, 'h200, 1, 1, 0, 'h050, 0, 0, 0));
         else         step(mk(1, 'h200 + i, 1, 1, 0, 'h050, 0, 1, 0));
      end
      step(mk(1, 'h042, 0, 1, 0, 'h050, 0, 1, 0));
      step(mk(1, 'h043, 0, 1, 0, 'h050, 0, 1, 0));
      step(mk(1, 'h044, 0, 1, 0, 'h050, 0, 0, 1));

      // Lock rising in the forced-grant cycle wins and keeps the limit
      for (int i = 0; i < SMAX; i++) step(mk(1, 'h300 + i, 0, 1, 0, 'h060, 0, 1, 0));
      step(mk(1, 'h310, 1, 1, 0, 'h060, 0, 1, 0));
      step(mk(1, 'h311, 1, 1, 0, 'h060, 0, 1, 0));
      step(mk(1, 'h312, 0, 1, 0, 'h060, 0, 1, 0));
      step(mk(1, 'h313, 0, 1, 0, 'h060, 0, 0, 1));

      // Host drops while forced: counter clears, full starvation window again
      for (int i = 0; i < SMAX; i++) step(mk(1, 'h400 + i, 0, 1, 0, 'h070, 0, 1, 0));
      step(mk(1, 'h410, 0, 0, 0, 'h070, 0, 1, 0));
      for (int i = 0; i < SMAX; i++) step(mk(1, 'h420 + i, 0, 1, 0, 'h071, 0, 1, 0));
      step(mk(1, 'h430, 0, 1, 0, 'h071, 0, 0, 1));
      for (int i = 0; i <= RD_LAT; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));

      // Reset one cycle after a read grant: the read never returns
      step(mk(1, 'h030, 0, 0, 0, 'h000, 0, 1, 0));
      rst_n = 1'b0;
      sb.delete();
      last_addr = '0; last_wd = '0; wd_known = 1'b1;
      for (int i = 0; i < 3; i++) step(mk(1, 'h031, 0, 1, 0, 'h032, 0, 0, 0));
      rst_n = 1'b1;
      for (int i = 0; i <= RD_LAT; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
